life_mem_sched: RTL and testbench

Arbiter and generation scheduler for the shared single-port cell memory of the 80x60 Game of Life grid (one cell = 8x8 pixels at 640x480).
- The VGA pixel pipeline reads cells for display.
- The life update engine reads and writes cells to compute generations.
- This block grants the memory port and paces engine runs to vertical sync.
- Sits between vgaHVsyncGen-driven pixel logic, the life engine, and the cell RAM.

---
 rtl/life_mem_sched.sv | 175 +++++++++++++++++
 tb/tb_life_mem_sched.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_mem_sched.sv
// Cell-memory arbiter (display over engine) and vsync-paced generation scheduler for the Life grid.
// Optional build macro LIFE_STEP_EN adds pause/step control of generation starts.
module life_mem_sched #(
    parameter logic [7:0] FRAMES_PER_GEN = 8'd30,
    parameter int         ADDR_W         = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vsync,
`ifdef LIFE_STEP_EN
    input  logic              pause,
    input  logic              step,
`endif
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic              disp_rdata,
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic              eng_wdata,
    output logic              eng_gnt,
    output logic              eng_rvalid,
    output logic              eng_rdata,
    output logic              gen_start,
    input  logic              gen_done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_wdata,
    input  logic              mem_rdata
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // A frame count limit of zero would never saturate, so it behaves as one.
    function automatic logic [7:0] sat_limit(input logic [7:0] fpg);
        if (fpg == 8'd0) begin
            return 8'd1;
        end else begin
            return fpg;
        end
    endfunction

    localparam logic [7:0] SAT_VAL = sat_limit(FRAMES_PER_GEN);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              vsync_q, vsync_d;
    logic              gen_start_q, gen_start_d;
    logic              busy_q, busy_d;
    logic              disp_valid_q, disp_valid_d;
    logic              eng_rvalid_q, eng_rvalid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              eng_gnt_s;
    logic              mem_we_s;
    logic              mem_wdata_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic              frame_edge_s;
    logic [7:0]        cnt_inc_s;
    logic              start_s;
    logic              pause_s;
    logic              step_s;

`ifdef LIFE_STEP_EN
    assign pause_s = pause;
    assign step_s  = step;
`else
    assign pause_s = 1'b0;
    assign step_s  = 1'b0;
`endif

    // Fixed-priority port mux; an idle port keeps the last address on the RAM.
    always_comb begin
        eng_gnt_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_wdata_s = 1'b0;
        mem_addr_s  = addr_q;
        if (disp_req) begin
            mem_addr_s = disp_addr;
        end else if (eng_req) begin
            eng_gnt_s   = 1'b1;
            mem_addr_s  = eng_addr;
            mem_we_s    = eng_we;
            mem_wdata_s = eng_wdata;
        end else begin
            mem_addr_s = addr_q;
        end
        addr_d       = mem_addr_s;
        disp_valid_d = disp_req;
        eng_rvalid_d = eng_gnt_s & ~eng_we;
    end

    // Frame counting and the IDLE/RUN generation sequencer.
    always_comb begin
        vsync_d      = vsync;
        frame_edge_s = vsync_q & ~vsync;
        if (frame_edge_s && (cnt_q < SAT_VAL)) begin
            cnt_inc_s = cnt_q + 8'd1;
        end else begin
            cnt_inc_s = cnt_q;
        end
        if (pause_s) begin
            start_s = step_s;
        end else begin
            start_s = (cnt_q == SAT_VAL);
        end
        state_d     = state_q;
        cnt_d       = cnt_inc_s;
        gen_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    // An edge landing on the start cycle counts toward the next generation.
                    gen_start_d = 1'b1;
                    cnt_d       = frame_edge_s ? 8'd1 : 8'd0;
                    state_d     = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (gen_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        busy_d = (state_d == ST_RUN);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            vsync_q      <= 1'b1;
            gen_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            disp_valid_q <= 1'b0;
            eng_rvalid_q <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vsync_q      <= vsync_d;
            gen_start_q  <= gen_start_d;
            busy_q       <= busy_d;
            disp_valid_q <= disp_valid_d;
            eng_rvalid_q <= eng_rvalid_d;
            addr_q       <= addr_d;
        end
    end

    assign disp_valid = disp_valid_q;
    assign disp_rdata = disp_valid_q & mem_rdata;
    assign eng_rvalid = eng_rvalid_q;
    assign eng_rdata  = eng_rvalid_q & mem_rdata;
    assign eng_gnt    = eng_gnt_s;
    assign gen_start  = gen_start_q;
    assign busy       = busy_q;
    assign mem_addr   = mem_addr_s;
    assign mem_we     = mem_we_s;
    assign mem_wdata  = mem_wdata_s;

endmodule

// File: tb/tb_life_mem_sched.sv
// Randomized bench for life_mem_sched: three instances (3, 2 and 0 frames per generation)
// share all stimulus and are compared every cycle with a frame/generation reference model.
module tb_life_mem_sched;

    localparam int ADDR_W = 13;
    localparam int NI     = 3;
    localparam int FL     = 20;

    function automatic logic [7:0] fpg_of(input int g);
        case (g)
            0:       return 8'd3;
            1:       return 8'd2;
            default: return 8'd0;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              vsync;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              eng_req;
    logic              eng_we;
    logic [ADDR_W-1:0] eng_addr;
    logic              eng_wdata;
    logic              mem_rdata;
    logic              gen_done [NI];
    logic              tb_pause;
    logic              tb_step;

    logic              disp_valid_w [NI];
    logic              disp_rdata_w [NI];
    logic              eng_gnt_w    [NI];
    logic              eng_rvalid_w [NI];
    logic              eng_rdata_w  [NI];
    logic              gen_start_w  [NI];
    logic              busy_w       [NI];
    logic [ADDR_W-1:0] mem_addr_w   [NI];
    logic              mem_we_w     [NI];
    logic              mem_wdata_w  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        life_mem_sched #(
            .FRAMES_PER_GEN(fpg_of(g)),
            .ADDR_W        (ADDR_W)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .vsync     (vsync),
`ifdef LIFE_STEP_EN
            .pause     (tb_pause),
            .step      (tb_step),
`endif
            .disp_req  (disp_req),
            .disp_addr (disp_addr),
            .disp_valid(disp_valid_w[g]),
            .disp_rdata(disp_rdata_w[g]),
            .eng_req   (eng_req),
            .eng_we    (eng_we),
            .eng_addr  (eng_addr),
            .eng_wdata (eng_wdata),
            .eng_gnt   (eng_gnt_w[g]),
            .eng_rvalid(eng_rvalid_w[g]),
            .eng_rdata (eng_rdata_w[g]),
            .gen_start (gen_start_w[g]),
            .gen_done  (gen_done[g]),
            .busy      (busy_w[g]),
            .mem_addr  (mem_addr_w[g]),
            .mem_we    (mem_we_w[g]),
            .mem_wdata (mem_wdata_w[g]),
            .mem_rdata (mem_rdata)
        );
    end

    int total = 0;
    int bad   = 0;

    // Reference model state
    int                m_cnt   [NI];
    bit                m_run   [NI];
    bit                m_start [NI];
    int                m_dly   [NI];
    bit                m_vs_prev;
    bit                m_dvalid;
    bit                m_rvalid;
    logic [ADDR_W-1:0] m_last_addr;
    bit                pend;
    int                frame_pos;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_of(input int k);
        return (fpg_of(k) == 8'd0) ? 1 : int'(fpg_of(k));
    endfunction

    task automatic advance_frame();
        frame_pos = (frame_pos + 1) % FL;
        vsync     = (frame_pos >= 2);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_cnt[k]   = 0;
            m_run[k]   = 1'b0;
            m_start[k] = 1'b0;
            m_dly[k]   = 0;
        end
        m_vs_prev   = 1'b1;
        m_dvalid    = 1'b0;
        m_rvalid    = 1'b0;
        m_last_addr = '0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        disp_req = 1'b0;
        eng_req  = 1'b0;
        pend     = 1'b0;
        tb_step  = 1'b0;
        for (int k = 0; k < NI; k++) gen_done[k] = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check_val($sformatf("rst_busy%0d", k), busy_w[k], 0);
            check_val($sformatf("rst_start%0d", k), gen_start_w[k], 0);
            check_val($sformatf("rst_dvalid%0d", k), disp_valid_w[k], 0);
            check_val($sformatf("rst_rvalid%0d", k), eng_rvalid_w[k], 0);
            check_val($sformatf("rst_we%0d", k), mem_we_w[k], 0);
        end
        model_reset();
        repeat (2) begin
            @(negedge clk);
            advance_frame();
        end
        reset = 1'b0;
    endtask

    task automatic gen_inputs();
        advance_frame();
        disp_req  = ($urandom % 3 == 0);
        disp_addr = ADDR_W'($urandom);
        if (!pend && ($urandom % 3 == 0)) begin
            pend      = 1'b1;
            eng_we    = $urandom % 2;
            eng_wdata = $urandom % 2;
            case ($urandom % 4)
                0:       eng_addr = ADDR_W'(4799);
                1:       eng_addr = ADDR_W'($urandom_range(4800, 8191));
                default: eng_addr = ADDR_W'($urandom % 4800);
            endcase
        end
        eng_req   = pend;
        mem_rdata = $urandom % 2;
        for (int k = 0; k < NI; k++) begin
            if (m_run[k]) begin
                if (m_dly[k] == 0) begin
                    gen_done[k] = 1'b1;
                end else begin
                    gen_done[k] = 1'b0;
                    m_dly[k]--;
                end
            end else begin
                gen_done[k] = ($urandom % 40 == 0);
            end
        end
    endtask

    // Check this cycle's outputs, then advance the model across the coming clock edge.
    task automatic do_cycle();
        bit                e_gnt;
        bit                edge_seen;
        bit                sc;
        logic [ADDR_W-1:0] e_addr;
        #1;
        e_gnt  = eng_req && !disp_req;
        e_addr = disp_req ? disp_addr : (eng_req ? eng_addr : m_last_addr);
        for (int k = 0; k < NI; k++) begin
            check_val($sformatf("gnt%0d", k), eng_gnt_w[k], e_gnt);
            check_val($sformatf("addr%0d", k), mem_addr_w[k], e_addr);
            check_val($sformatf("we%0d", k), mem_we_w[k], e_gnt && eng_we);
            if (e_gnt) check_val($sformatf("wdata%0d", k), mem_wdata_w[k], eng_wdata);
            check_val($sformatf("dvalid%0d", k), disp_valid_w[k], m_dvalid);
            check_val($sformatf("rvalid%0d", k), eng_rvalid_w[k], m_rvalid);
            if (m_dvalid) check_val($sformatf("drdata%0d", k), disp_rdata_w[k], mem_rdata);
            if (m_rvalid) check_val($sformatf("erdata%0d", k), eng_rdata_w[k], mem_rdata);
            check_val($sformatf("gen_start%0d", k), gen_start_w[k], m_start[k]);
            check_val($sformatf("busy%0d", k), busy_w[k], m_run[k]);
        end
        m_dvalid    = disp_req;
        m_rvalid    = e_gnt && !eng_we;
        m_last_addr = e_addr;
        edge_seen   = m_vs_prev && !vsync;
        m_vs_prev   = vsync;
        for (int k = 0; k < NI; k++) begin
            m_start[k] = 1'b0;
            if (!m_run[k]) begin
                sc = tb_pause ? tb_step : (m_cnt[k] == sat_of(k));
                if (sc) begin
                    m_start[k] = 1'b1;
                    m_run[k]   = 1'b1;
                    m_cnt[k]   = edge_seen ? 1 : 0;
                    m_dly[k]   = ($urandom % 2 == 0) ? 5 : $urandom_range(70, 100);
                end else if (edge_seen && m_cnt[k] < sat_of(k)) begin
                    m_cnt[k]++;
                end
            end else begin
                if (edge_seen && m_cnt[k] < sat_of(k)) m_cnt[k]++;
                if (gen_done[k]) m_run[k] = 1'b0;
            end
        end
        if (e_gnt) pend = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int  resets_done;
        bit  stepped;
        bit  all_idle;
        reset     = 1'b1;
        vsync     = 1'b1;
        frame_pos = 5;
        disp_req  = 1'b0;
        disp_addr = '0;
        eng_req   = 1'b0;
        eng_we    = 1'b0;
        eng_addr  = '0;
        eng_wdata = 1'b0;
        mem_rdata = 1'b0;
        tb_pause  = 1'b0;
        tb_step   = 1'b0;
        pend      = 1'b0;
        for (int k = 0; k < NI; k++) gen_done[k] = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Display and engine collide: display wins, engine follows next cycle.
        advance_frame();
        disp_req  = 1'b1;
        disp_addr = ADDR_W'(100);
        pend      = 1'b1;
        eng_req   = 1'b1;
        eng_we    = 1'b0;
        eng_addr  = ADDR_W'(555);
        do_cycle();
        advance_frame();
        disp_req = 1'b0;
        do_cycle();
        // Engine read of the last cell, RAM returns 1.
        advance_frame();
        pend     = 1'b1;
        eng_req  = 1'b1;
        eng_addr = ADDR_W'(4799);
        do_cycle();
        advance_frame();
        eng_req   = 1'b0;
        mem_rdata = 1'b1;
        do_cycle();

        resets_done = 0;
        stepped     = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            tb_step = 1'b0;
`ifdef LIFE_STEP_EN
            tb_pause = (i >= 2000 && i < 2400);
            all_idle = 1'b1;
            for (int k = 0; k < NI; k++) if (m_run[k]) all_idle = 1'b0;
            if (i >= 2200 && i < 2400 && !stepped && all_idle) begin
                tb_step = 1'b1;
                stepped = 1'b1;
            end
`else
            all_idle = 1'b0;
`endif
            if (i > 500 && resets_done < 3 && m_run[1] && (i % 300 < 10)) begin
                resets_done++;
                do_reset();
            end
            gen_inputs();
            do_cycle();
        end
`ifdef LIFE_STEP_EN
        check_val("step_issued", stepped, 1);
`endif
        check_val("mid_run_resets", resets_done, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
